// File: rtl/cpu_if.sv
// rtl/cpu_if.sv - fetch stage and IF/ID pipeline register of the 16-bit pipelined CPU
//
// Owns the PC, drives the instruction-memory address, registers the fetched
// word and its PC+2 for decode, applies branch redirects, stalls and flushes,
// and freezes fetch once an HLT instruction has been fetched.
//
// Ports:
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   imemAddr     out  16  instruction-memory address (the PC register)
//   imemData     in   16  instruction word at imemAddr, same cycle
//   stallF       in   1   hold PC, IF/ID and halt state
//   branchTaken  in   1   decode stage resolved a taken branch
//   branchTarget in   16  redirect PC from decode
//   instrD       out  16  IF/ID instruction
//   pcD          out  16  IF/ID PC+2 of instrD
//   validD       out  1   instrD is a real fetched instruction
//   frozen       out  1   HLT fetched, fetch stopped
module cpu_if #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        stallF,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  output logic [15:0] instrD,
  output logic [15:0] pcD,
  output logic        validD,
  output logic        frozen
);

  typedef enum logic {RUN = 1'b0, FROZEN = 1'b1} state_t;

  state_t      state;
  state_t      stateNext;
  logic [15:0] pc;
  logic [15:0] pcNext;
  logic [15:0] pcPlus2;
  logic [15:0] instrNext;
  logic [15:0] pcDNext;
  logic        validNext;
  logic        hltF;

  // Memory address comes straight from the PC register so the imem path
  // never sees the redirect/stall muxing.
  assign imemAddr = pc;
  assign frozen   = (state == FROZEN);
  assign pcPlus2  = pc + 16'd2;
  assign hltF     = (imemData[15:12] == HLT_OPCODE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC;
      instrD <= NOP_INSTR;
      pcD    <= 16'h0000;
      validD <= 1'b0;
    end else begin
      state  <= stateNext;
      pc     <= pcNext;
      instrD <= instrNext;
      pcD    <= pcDNext;
      validD <= validNext;
    end
  end

  // Priority: stall > branch > frozen > normal fetch.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    instrNext = instrD;
    pcDNext   = pcD;
    validNext = validD;
    if (stallF) begin
      // everything holds; a coincident redirect is dropped
    end else if (branchTaken) begin
      // Flush the wrong-path word; a redirect while frozen moves the PC but
      // does not leave FROZEN.
      pcNext    = branchTarget;
      instrNext = NOP_INSTR;
      validNext = 1'b0;
      pcDNext   = pcPlus2;
    end else if (state == FROZEN) begin
      instrNext = NOP_INSTR;
      validNext = 1'b0;
    end else begin
      instrNext = imemData;
      pcDNext   = pcPlus2;
      validNext = 1'b1;
      // The HLT word itself goes down the pipe; the PC parks on it.
      if (hltF) begin
        stateNext = FROZEN;
      end else begin
        pcNext = pcPlus2;
      end
    end
  end

endmodule

// File: tb/tb_cpu_if.sv
// tb/tb_cpu_if.sv - directed self-checking bench for cpu_if
module tb_cpu_if;

  logic        clk;
  logic        rst;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        stallF;
  logic        branchTaken;
  logic [15:0] branchTarget;
  logic [15:0] instrD;
  logic [15:0] pcD;
  logic        validD;
  logic        frozen;

  logic [15:0] imemAddr2;
  logic [15:0] instrD2;
  logic [15:0] pcD2;
  logic        validD2;
  logic        frozen2;

  int total = 0;
  int bad   = 0;

  cpu_if dut (
    .clk(clk), .rst(rst), .imemAddr(imemAddr), .imemData(imemData),
    .stallF(stallF), .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instrD(instrD), .pcD(pcD), .validD(validD), .frozen(frozen)
  );

  cpu_if #(.RESET_PC(16'hFFFC)) dutWrap (
    .clk(clk), .rst(rst), .imemAddr(imemAddr2), .imemData(16'h1234),
    .stallF(1'b0), .branchTaken(1'b0), .branchTarget(16'h0000),
    .instrD(instrD2), .pcD(pcD2), .validD(validD2), .frozen(frozen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle on the falling edge where checks and new
  // stimulus happen.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] data, input logic st,
                       input logic br, input logic [15:0] tgt);
    imemData     = data;
    stallF       = st;
    branchTaken  = br;
    branchTarget = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h1234, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset got addr=%h instr=%h pcD=%h v=%b f=%b exp 0000 0000 0000 0 0",
               imemAddr, instrD, pcD, validD, frozen);
    end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if ({imemAddr, instrD, pcD, validD, frozen} !== {16'(2*i), 16'h1234, 16'(2*i), 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL seq%0d got addr=%h instr=%h pcD=%h v=%b f=%b exp addr=pcD=%h instr=1234 v=1",
                 i, imemAddr, instrD, pcD, validD, frozen, 16'(2*i));
      end
    end
  endtask

  task automatic test_stall();
    // PC=8 now; redirect to 000E, fetch one word to land PC on 0010.
    drive(16'hAAAA, 1'b0, 1'b1, 16'h000E);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h000E, 16'h0000, 16'h000A, 1'b0}) begin
      bad++;
      $display("FAIL stall_setup_br got addr=%h instr=%h pcD=%h v=%b exp 000e 0000 000a 0",
               imemAddr, instrD, pcD, validD);
    end
    drive(16'h1111, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h0010, 16'h1111, 16'h0010, 1'b1}) begin
      bad++;
      $display("FAIL stall_setup got addr=%h instr=%h pcD=%h v=%b exp 0010 1111 0010 1",
               imemAddr, instrD, pcD, validD);
    end
    drive(16'h2222, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({imemAddr, instrD, pcD, validD} !== {16'h0010, 16'h1111, 16'h0010, 1'b1}) begin
        bad++;
        $display("FAIL stall_hold%0d got addr=%h instr=%h pcD=%h v=%b exp 0010 1111 0010 1",
                 i, imemAddr, instrD, pcD, validD);
      end
    end
    stallF = 1'b0;
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h0012, 16'h2222, 16'h0012, 1'b1}) begin
      bad++;
      $display("FAIL stall_release got addr=%h instr=%h pcD=%h v=%b exp 0012 2222 0012 1",
               imemAddr, instrD, pcD, validD);
    end
  endtask

  task automatic test_branch();
    drive(16'h9999, 1'b0, 1'b1, 16'h001E);
    tick();
    drive(16'h3333, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if (imemAddr !== 16'h0020) begin
      bad++;
      $display("FAIL br_setup got addr=%h exp 0020", imemAddr);
    end
    drive(16'h8888, 1'b0, 1'b1, 16'h0100);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h0100, 16'h0000, 16'h0022, 1'b0}) begin
      bad++;
      $display("FAIL br_flush got addr=%h instr=%h pcD=%h v=%b exp 0100 0000 0022 0",
               imemAddr, instrD, pcD, validD);
    end
    drive(16'h4444, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h0102, 16'h4444, 16'h0102, 1'b1}) begin
      bad++;
      $display("FAIL br_after got addr=%h instr=%h pcD=%h v=%b exp 0102 4444 0102 1",
               imemAddr, instrD, pcD, validD);
    end
    drive(16'h7777, 1'b1, 1'b1, 16'h0201);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD} !== {16'h0102, 16'h4444, 16'h0102, 1'b1}) begin
      bad++;
      $display("FAIL br_stall got addr=%h instr=%h pcD=%h v=%b exp 0102 4444 0102 1",
               imemAddr, instrD, pcD, validD);
    end
    drive(16'h5555, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD} !== {16'h0104, 16'h5555, 16'h0104}) begin
      bad++;
      $display("FAIL br_resume got addr=%h instr=%h pcD=%h exp 0104 5555 0104",
               imemAddr, instrD, pcD);
    end
    // Odd target: bit 0 must pass through untouched.
    drive(16'h5555, 1'b0, 1'b1, 16'h0123);
    tick();
    total++;
    if (imemAddr !== 16'h0123) begin
      bad++;
      $display("FAIL br_odd got addr=%h exp 0123", imemAddr);
    end
  endtask

  task automatic test_halt();
    // HLT coinciding with a branch is discarded.
    drive(16'hF000, 1'b0, 1'b1, 16'h003E);
    tick();
    total++;
    if ({imemAddr, validD, frozen} !== {16'h003E, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL hlt_br got addr=%h v=%b f=%b exp 003e 0 0", imemAddr, validD, frozen);
    end
    drive(16'h6666, 1'b0, 1'b0, 16'h0000);
    tick();
    // HLT seen during a stall waits for the stall to drop.
    drive(16'hF000, 1'b1, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, frozen} !== {16'h0040, 16'h6666, 1'b0}) begin
      bad++;
      $display("FAIL hlt_stall got addr=%h instr=%h f=%b exp 0040 6666 0", imemAddr, instrD, frozen);
    end
    stallF = 1'b0;
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0040, 16'hF000, 16'h0042, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL hlt_fetch got addr=%h instr=%h pcD=%h v=%b f=%b exp 0040 f000 0042 1 1",
               imemAddr, instrD, pcD, validD, frozen);
    end
    drive(16'h7777, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0040, 16'h0000, 16'h0042, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL hlt_frozen%0d got addr=%h instr=%h pcD=%h v=%b f=%b exp 0040 0000 0042 0 1",
                 i, imemAddr, instrD, pcD, validD, frozen);
      end
    end
    drive(16'h7777, 1'b0, 1'b1, 16'h0080);
    tick();
    drive(16'h7777, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0080, 16'h0000, 16'h0042, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL hlt_redirect got addr=%h instr=%h pcD=%h v=%b f=%b exp 0080 0000 0042 0 1",
               imemAddr, instrD, pcD, validD, frozen);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL async_rst got addr=%h instr=%h pcD=%h v=%b f=%b exp 0000 0000 0000 0 0",
               imemAddr, instrD, pcD, validD, frozen);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(16'h1234, 1'b0, 1'b0, 16'h0000);
    tick();
    total++;
    if ({imemAddr, instrD, pcD, validD, frozen} !== {16'h0002, 16'h1234, 16'h0002, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_restart got addr=%h instr=%h pcD=%h v=%b f=%b exp 0002 1234 0002 1 0",
               imemAddr, instrD, pcD, validD, frozen);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] expAddr [4];
    logic [15:0] expPcD [4];
    expAddr = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
    expPcD  = '{16'h0000, 16'hFFFE, 16'h0000, 16'h0002};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++;
      if ({imemAddr2, pcD2} !== {expAddr[i], expPcD[i]}) begin
        bad++;
        $display("FAIL wrap%0d got addr=%h pcD=%h exp addr=%h pcD=%h",
                 i, imemAddr2, pcD2, expAddr[i], expPcD[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h1234, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
